// File: rtl/weight_column_loader.sv
// Column-write side of weightRAM: gathers ROWS streamed weights into one column,
// writes it at colAddressWrite, and pulses loadDone after COLS columns.
module weight_column_loader #(
    parameter int ROWS          = 32,
    parameter int COLS          = 4,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int ADDR_BITWIDTH = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       loadStart,
    input  logic [BITWIDTH-1:0]        wordIn,
    input  logic                       wordValid,
    output logic                       wordReady,
    output logic [ADDR_BITWIDTH-1:0]   colAddressWrite,
    output logic                       writeEn,
    output logic [ROWS*BITWIDTH-1:0]   weightMemInput,
    output logic                       busy,
    output logic                       loadDone
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ROW_W-1:0]         LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(COLS - 1);

    logic [1:0]               r_state;
    logic [ROW_W-1:0]         r_rowCnt;
    logic [ADDR_BITWIDTH-1:0] r_colCnt;
    logic                     r_wordReady;
    logic                     r_writeEn;
    logic [ADDR_BITWIDTH-1:0] r_colAddr;
    logic [ROWS*BITWIDTH-1:0] r_mem;
    logic                     r_busy;
    logic                     r_loadDone;
    logic                     w_accept;

    assign w_accept = (r_state == S_FILL) && wordValid && r_wordReady;

    // Outputs are registered, so each transition also loads the flags of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rowCnt    <= '0;
            r_colCnt    <= '0;
            r_wordReady <= 1'b0;
            r_writeEn   <= 1'b0;
            r_colAddr   <= '0;
            r_mem       <= '0;
            r_busy      <= 1'b0;
            r_loadDone  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (loadStart) begin
                        r_rowCnt    <= '0;
                        r_colCnt    <= '0;
                        r_wordReady <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_mem[int'(r_rowCnt)*BITWIDTH +: BITWIDTH] <= wordIn;
                        if (r_rowCnt == LAST_ROW) begin
                            r_wordReady <= 1'b0;
                            r_writeEn   <= 1'b1;
                            r_colAddr   <= r_colCnt;
                            r_state     <= S_WRITE;
                        end else begin
                            r_rowCnt <= r_rowCnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_writeEn <= 1'b0;
                    if (r_colCnt == LAST_COL) begin
                        r_loadDone <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_colCnt    <= r_colCnt + 1'b1;
                        r_rowCnt    <= '0;
                        r_wordReady <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                S_DONE: begin
                    r_loadDone <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wordReady       = r_wordReady;
    assign writeEn         = r_writeEn;
    assign colAddressWrite = r_colAddr;
    assign weightMemInput  = r_mem;
    assign busy            = r_busy;
    assign loadDone        = r_loadDone;

endmodule

// File: tb/tb_weight_column_loader.sv
// Scoreboard bench: a W_x-sized (4 column) and a W_y-sized (32 column) loader
// share the stream; expected columns are queued at issue time and popped on writeEn.
module tb_weight_column_loader;

    localparam int ROWS   = 32;
    localparam int BW     = 18;
    localparam int COLS_X = 4;
    localparam int COLS_Y = 32;
    localparam int DW     = ROWS * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lsA = 1'b0;
    logic          lsB = 1'b0;
    logic          wordValid = 1'b0;
    logic [BW-1:0] wordIn = '0;

    logic          rdyA, weA, busyA, doneA;
    logic [1:0]    addrA;
    logic [DW-1:0] memA;
    logic          rdyB, weB, busyB, doneB;
    logic [4:0]    addrB;
    logic [DW-1:0] memB;

    always #5 clk = ~clk;

    weight_column_loader #(.ROWS(ROWS), .COLS(COLS_X)) u_wx (
        .clock(clk), .reset(reset), .loadStart(lsA), .wordIn(wordIn),
        .wordValid(wordValid), .wordReady(rdyA), .colAddressWrite(addrA),
        .writeEn(weA), .weightMemInput(memA), .busy(busyA), .loadDone(doneA)
    );

    weight_column_loader #(.ROWS(ROWS), .COLS(COLS_Y)) u_wy (
        .clock(clk), .reset(reset), .loadStart(lsB), .wordIn(wordIn),
        .wordValid(wordValid), .wordReady(rdyB), .colAddressWrite(addrB),
        .writeEn(weB), .weightMemInput(memB), .busy(busyB), .loadDone(doneB)
    );

    typedef struct {
        int            inst;
        int            addr;
        logic [DW-1:0] data;
        int            ecyc;
    } col_t;

    col_t qcol[$];
    int   qdone_inst[$];
    int   qdone_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic mon(input int inst, input logic we, input int addr, input logic [DW-1:0] mem,
                       input logic ld, input logic rdy);
        col_t e;
        if (we) begin
            if (qcol.size() == 0) flag("unexpected_writeEn");
            else begin
                e = qcol.pop_front();
                chk("wr_inst", DW'(inst), DW'(e.inst));
                chk("wr_addr", DW'(addr), DW'(e.addr));
                chk("wr_data", mem, e.data);
                if (e.ecyc >= 0) chk("wr_cycle", DW'(cyc - start_cyc), DW'(e.ecyc));
            end
        end
        if (ld) begin
            if (qdone_inst.size() == 0) flag("unexpected_loadDone");
            else begin
                chk("done_inst", DW'(inst), DW'(qdone_inst.pop_front()));
                e.ecyc = qdone_cyc.pop_front();
                if (e.ecyc >= 0) chk("done_cycle", DW'(cyc - start_cyc), DW'(e.ecyc));
            end
        end
        if (we || ld) chk("ready_low_write_done", DW'(rdy), '0);
    endtask

    always @(negedge clk) begin
        mon(0, weA, int'(addrA), memA, doneA, rdyA);
        mon(1, weB, int'(addrB), memB, doneB, rdyB);
    end

    task automatic set_ls(input int inst, input logic v);
        if (inst == 0) lsA = v;
        else lsB = v;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready_x", DW'(rdyA), '0);
        chk("rst_we_x",    DW'(weA), '0);
        chk("rst_addr_x",  DW'(addrA), '0);
        chk("rst_mem_x",   memA, '0);
        chk("rst_busy_x",  DW'(busyA), '0);
        chk("rst_done_x",  DW'(doneA), '0);
        chk("rst_ready_y", DW'(rdyB), '0);
        chk("rst_busy_y",  DW'(busyB), '0);
        chk("rst_mem_y",   memB, '0);
    endtask

    // dmode: 0 index, 1 random, 2 signed extremes then random.
    // gmode: 0 valid always, 1 drop every 3rd cycle, 2 random gaps.
    task automatic run_load(input int inst, input int cols, input int dmode, input int gmode,
                            input int abort_at, input bit extra, input bit timed, input bit done_start);
        logic [BW-1:0] words[$];
        col_t          e;
        int            n;
        int            lim;
        int            idx;
        int            guard;
        int            g;
        logic          v;
        logic          rdy;
        logic          seen;
        n = cols * ROWS;
        words = {};
        for (int i = 0; i < n; i++) begin
            case (dmode)
                0:       words.push_back(BW'(i));
                1:       words.push_back(BW'($urandom));
                default: words.push_back(i < 8 ? ((i % 2 == 0) ? 18'h20000 : 18'h1FFFF) : BW'($urandom));
            endcase
        end
        for (int c = 0; c < cols; c++) begin
            if (abort_at < 0 || (c + 1) * ROWS <= abort_at) begin
                e.inst = inst;
                e.addr = c;
                e.data = '0;
                for (int r = 0; r < ROWS; r++) e.data[r*BW +: BW] = words[c*ROWS + r];
                e.ecyc = timed ? (c + 1) * (ROWS + 1) : -1;
                qcol.push_back(e);
            end
        end
        if (abort_at < 0) begin
            qdone_inst.push_back(inst);
            qdone_cyc.push_back(timed ? cols * (ROWS + 1) + 1 : -1);
        end
        @(negedge clk);
        set_ls(inst, 1'b1);
        wordValid = 1'b0;
        start_cyc = cyc;
        lim = (abort_at < 0) ? n : abort_at;
        idx = 0;
        guard = 0;
        g = 0;
        while (idx < lim && guard < 8 * n + 100) begin
            @(negedge clk);
            guard++;
            g++;
            v = (gmode == 0) ? 1'b1 : (gmode == 1) ? (g % 3 != 0) : ($urandom_range(0, 3) != 0);
            wordValid = v;
            wordIn = words[idx];
            set_ls(inst, extra ? ($urandom_range(0, 3) == 0) : 1'b0);
            rdy = (inst == 0) ? rdyA : rdyB;
            if (v && rdy) idx++;
        end
        if (idx < lim) flag("feed_timeout");
        if (abort_at >= 0) begin
            @(negedge clk);
            reset = 1'b1;
            wordValid = 1'b0;
            set_ls(inst, 1'b0);
            @(negedge clk);
            check_reset_outputs();
            reset = 1'b0;
        end else begin
            guard = 0;
            seen = 1'b0;
            while (!seen && guard < 200) begin
                @(negedge clk);
                guard++;
                wordValid = $urandom_range(0, 1) == 1;
                wordIn = BW'($urandom);
                set_ls(inst, 1'b0);
                seen = (inst == 0) ? doneA : doneB;
            end
            if (!seen) flag("loadDone_timeout");
            if (done_start) begin
                set_ls(inst, 1'b1);
                @(negedge clk);
                set_ls(inst, 1'b0);
                wordValid = 1'b0;
                repeat (3) @(negedge clk);
                chk("ls_in_done_ignored", DW'(inst == 0 ? busyA : busyB), '0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_load(0, COLS_X, 0, 0, -1, 1'b0, 1'b1, 1'b0);
        run_load(0, COLS_X, 0, 1, -1, 1'b0, 1'b0, 1'b0);
        run_load(0, COLS_X, 1, 2, -1, 1'b0, 1'b0, 1'b0);
        run_load(0, COLS_X, 1, 2, -1, 1'b1, 1'b0, 1'b1);

        run_load(0, COLS_X, 1, 0, ROWS + 10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wordValid = 1'b1;
            wordIn = BW'($urandom);
        end
        chk("idle_after_reset_busy", DW'(busyA), '0);
        wordValid = 1'b0;

        run_load(1, COLS_Y, 1, 2, -1, 1'b0, 1'b0, 1'b0);
        run_load(1, COLS_Y, 1, 0, -1, 1'b0, 1'b1, 1'b0);

        run_load(0, COLS_X, 2, 0, -1, 1'b0, 1'b0, 1'b0);

        wordValid = 1'b0;
        repeat (5) @(negedge clk);
        chk("cols_pending", DW'(qcol.size()), '0);
        chk("done_pending", DW'(qdone_inst.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
